// File: rtl/hex_operand_editor.sv
// hex_operand_editor: push-button hex editor for NUM_REGS operand registers.
// Define HEX_EDIT_AUTOREPEAT_EN to enable hold-to-repeat on the digit buttons.
module hex_operand_editor #(
    parameter int WIDTH = 32,
    parameter int NUM_REGS = 2,
    parameter logic [NUM_REGS*WIDTH-1:0] INIT_VALS =
        {32'h12345678, 32'h87654321},
    parameter int DB_CYCLES = 16,
    parameter int REPEAT_DELAY = 64,
    parameter int REPEAT_PERIOD = 16,
    localparam int DIGITS = WIDTH / 4,
    localparam int SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
    localparam int CUR_W = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [3:0]                btn,
    input  logic                      edit_en,
    input  logic [SEL_W-1:0]          sel,
    output logic [NUM_REGS*WIDTH-1:0] regs_flat,
    output logic [CUR_W-1:0]          cursor,
    output logic [DIGITS-1:0]         blink,
    output logic                      edit_pulse
);

    localparam int DB_W = $clog2(DB_CYCLES + 1);

    if ((WIDTH % 4) != 0 || NUM_REGS < 1 || DB_CYCLES < 1 ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("hex_operand_editor: illegal parameter set");
    end

    logic [WIDTH-1:0] regs [NUM_REGS];
    logic [3:0]       s1, s2, acc, acc_d, rise_q, armed;
    logic [1:0]       warm;
    logic [DB_W-1:0]  cnt [4];
    logic             sel_ok;
    logic             cur_up, cur_dn, dig_up, dig_dn, do_edit;
    logic [3:0]       nib, nib_new;
    logic             rpt_fire, rpt_up;

    assign sel_ok = int'({1'b0, sel}) < NUM_REGS;

    // Synchronise raw buttons; warm marks when s2 holds real samples
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1   <= '0;
            s2   <= '0;
            warm <= '0;
        end else begin
            s1   <= btn;
            s2   <= s1;
            warm <= {warm[0], 1'b1};
        end
    end

    // Debounce: accept a new level after DB_CYCLES consecutive differing cycles
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (!rst_n) begin
                acc[i] <= 1'b0;
                cnt[i] <= '0;
            end else if (s2[i] == acc[i]) begin
                cnt[i] <= '0;
            end else if (cnt[i] == DB_W'(DB_CYCLES - 1)) begin
                acc[i] <= s2[i];
                cnt[i] <= '0;
            end else begin
                cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    // Registered press strobe; a button held through reset stays disarmed until released
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_d  <= '0;
            rise_q <= '0;
            armed  <= '0;
        end else begin
            acc_d  <= acc;
            rise_q <= acc & ~acc_d & armed;
            armed  <= armed | ({4{warm[1]}} & ~s2);
        end
    end

`ifdef HEX_EDIT_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                             REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W = $clog2(RPT_MAX + 1);

    logic             rpt_on, rpt_first, rpt_held;
    logic [RPT_W-1:0] rpt_cnt, rpt_lim;

    // Repeat strobe while the digit button that started the run stays held
    always_comb begin
        rpt_lim  = rpt_first ? RPT_W'(REPEAT_DELAY - 1) :
                               RPT_W'(REPEAT_PERIOD - 1);
        rpt_held = rpt_up ? acc[2] : acc[3];
        rpt_fire = rpt_on & rpt_held & (rpt_cnt == rpt_lim);
    end

    // Repeat timer: restarted by each accepted digit press, stopped by release
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rpt_on    <= 1'b0;
            rpt_first <= 1'b0;
            rpt_up    <= 1'b0;
            rpt_cnt   <= '0;
        end else if (rise_q[2] | rise_q[3]) begin
            rpt_on    <= 1'b1;
            rpt_first <= 1'b1;
            rpt_up    <= rise_q[2];
            rpt_cnt   <= '0;
        end else if (!rpt_held) begin
            rpt_on    <= 1'b0;
        end else if (rpt_on) begin
            if (rpt_cnt == rpt_lim) begin
                rpt_cnt   <= '0;
                rpt_first <= 1'b0;
            end else begin
                rpt_cnt <= rpt_cnt + 1'b1;
            end
        end
    end
`else
    assign rpt_fire = 1'b0;
    assign rpt_up   = 1'b0;
`endif

    // Decode actions and compute the edited nibble from the pre-move cursor
    always_comb begin
        cur_up  = rise_q[0] & edit_en;
        cur_dn  = rise_q[1] & ~rise_q[0] & edit_en;
        dig_up  = rise_q[2] | (rpt_fire & rpt_up);
        dig_dn  = ~dig_up & (rise_q[3] | (rpt_fire & ~rpt_up));
        do_edit = (dig_up | dig_dn) & edit_en & sel_ok;
        nib     = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (SEL_W'(k) == sel) nib = regs[k][{cursor, 2'b00} +: 4];
        end
        nib_new = dig_up ? nib + 4'd1 : nib - 4'd1;
    end

    // Register file, cursor and edit strobe
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs[k] <= INIT_VALS[k*WIDTH +: WIDTH];
            end
            cursor     <= '0;
            edit_pulse <= 1'b0;
        end else begin
            edit_pulse <= do_edit;
            for (int k = 0; k < NUM_REGS; k++) begin
                if (do_edit && SEL_W'(k) == sel) begin
                    regs[k][{cursor, 2'b00} +: 4] <= nib_new;
                end
            end
            if (cur_up) begin
                cursor <= (cursor == CUR_W'(DIGITS - 1)) ? '0 : cursor + 1'b1;
            end else if (cur_dn) begin
                cursor <= (cursor == '0) ? CUR_W'(DIGITS - 1) : cursor - 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
        assign regs_flat[k*WIDTH +: WIDTH] = regs[k];
    end

    // Highlight the cursor digit only while an in-range register is editable
    always_comb begin
        blink = '0;
        if (edit_en && sel_ok) blink[cursor] = 1'b1;
    end

endmodule

// File: tb/tb_hex_operand_editor.sv
// tb_hex_operand_editor: scoreboard bench for hex_operand_editor.
// Stimulus queues expected events; a negedge monitor checks them.
module tb_hex_operand_editor;

    localparam int DB = 16;
    localparam int RD = 64;
    localparam int RP = 16;
    localparam logic [63:0] INIT = 64'h12345678_87654321;

    typedef struct {
        int          cur;
        logic [63:0] regs;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  btn;
    logic        edit_en;
    logic [0:0]  sel;
    logic [63:0] regs_flat;
    logic [2:0]  cursor;
    logic [7:0]  blink;
    logic        edit_pulse;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_cur = 0;

    hex_operand_editor #(
        .WIDTH(32),
        .NUM_REGS(2),
        .INIT_VALS(INIT),
        .DB_CYCLES(DB),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn(btn),
        .edit_en(edit_en),
        .sel(sel),
        .regs_flat(regs_flat),
        .cursor(cursor),
        .blink(blink),
        .edit_pulse(edit_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: any edit strobe or cursor move is one observed event
    always @(negedge clk) begin
        if (rst_n === 1'b1 && (edit_pulse === 1'b1 || int'(cursor) != last_cur)) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event cyc=%0d cursor=%0d regs=%h pulse=%b",
                         cyc, cursor, regs_flat, edit_pulse);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (int'(cursor) != e.cur || regs_flat !== e.regs || cyc != e.cyc) begin
                    bad++;
                    $display("FAIL event got cur=%0d regs=%h cyc=%0d want cur=%0d regs=%h cyc=%0d",
                             cursor, regs_flat, cyc, e.cur, e.regs, e.cyc);
                end
            end
        end
        last_cur = int'(cursor);
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic press(input logic [3:0] b, input int hold, input bit ev,
                         input int cur, input logic [63:0] r);
        @(negedge clk);
        if (ev) q.push_back('{cur, r, cyc + DB + 4});
        btn = b;
        repeat (hold) @(negedge clk);
        btn = 4'b0000;
        repeat (DB + 8) @(negedge clk);
    endtask

    initial begin
        int c0;
        rst_n   = 1'b0;
        btn     = 4'b0000;
        edit_en = 1'b1;
        sel     = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_regs", regs_flat, INIT);
        chk("reset_cursor", 64'(cursor), 64'd0);
        chk("reset_blink", 64'(blink), 64'h01);
        chk("reset_pulse", 64'(edit_pulse), 64'd0);
        repeat (4) @(negedge clk);

        press(4'b0100, DB + 5, 1'b1, 0, 64'h12345678_87654322);
        press(4'b0010, DB + 5, 1'b1, 7, 64'h12345678_87654322);
        chk("blink_wrap", 64'(blink), 64'h80);

        sel = 1'b1;
        press(4'b1000, DB + 5, 1'b1, 7, 64'h02345678_87654322);
        press(4'b1000, DB + 5, 1'b1, 7, 64'hF2345678_87654322);
        press(4'b0001, DB + 5, 1'b1, 0, 64'hF2345678_87654322);

        press(4'b0100, DB + 5, 1'b1, 0, 64'hF2345679_87654322);
        press(4'b0100, DB + 5, 1'b1, 0, 64'hF234567A_87654322);
        press(4'b0100, DB + 5, 1'b1, 0, 64'hF234567B_87654322);
        press(4'b0100, DB + 5, 1'b1, 0, 64'hF234567C_87654322);
        press(4'b0100, DB + 5, 1'b1, 0, 64'hF234567D_87654322);
        press(4'b0100, DB + 5, 1'b1, 0, 64'hF234567E_87654322);
        press(4'b0100, DB + 5, 1'b1, 0, 64'hF234567F_87654322);
        press(4'b0100, DB + 5, 1'b1, 0, 64'hF2345670_87654322);

        press(4'b0100, DB - 1, 1'b0, 0, 64'h0);
        chk("glitch_regs", regs_flat, 64'hF2345670_87654322);

        press(4'b0001, DB + 5, 1'b1, 1, 64'hF2345670_87654322);
        press(4'b0001, DB + 5, 1'b1, 2, 64'hF2345670_87654322);
        press(4'b0101, DB + 5, 1'b1, 3, 64'hF2345770_87654322);

        edit_en = 1'b0;
        @(negedge clk);
        chk("blink_disabled", 64'(blink), 64'h00);
        press(4'b0100, DB + 5, 1'b0, 0, 64'h0);
        press(4'b0001, DB + 5, 1'b0, 0, 64'h0);
        edit_en = 1'b1;
        @(negedge clk);
        chk("gated_regs", regs_flat, 64'hF2345770_87654322);
        chk("gated_cursor", 64'(cursor), 64'd3);

        @(negedge clk);
        c0 = cyc + DB + 4;
`ifdef HEX_EDIT_AUTOREPEAT_EN
        q.push_back('{3, 64'hF2346770_87654322, c0});
        q.push_back('{3, 64'hF2347770_87654322, c0 + RD});
        q.push_back('{3, 64'hF2348770_87654322, c0 + RD + RP});
        q.push_back('{3, 64'hF2349770_87654322, c0 + RD + 2 * RP});
`else
        q.push_back('{3, 64'hF2346770_87654322, c0});
`endif
        btn = 4'b0100;
        repeat (RD + 2 * RP + RP / 2 + 4) @(negedge clk);
        btn = 4'b0000;
        repeat (DB + 8) @(negedge clk);

        btn = 4'b0100;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        btn = 4'b0000;
        repeat (DB + 8) @(negedge clk);
        chk("held_reset_regs", regs_flat, INIT);
        chk("held_reset_cursor", 64'(cursor), 64'd0);
        press(4'b0100, DB + 5, 1'b1, 0, 64'h12345679_87654321);

        repeat (40) @(negedge clk);
        chk("pending_events", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
